adc_clip_rate_monitor: RTL

Per-window clip-rate statistics for the parallel ADC sample bus. Sits beside the ADC clipping flag logic on the same `din` bus, directly after ADC capture. It counts how many individual samples hit either signed full-scale code within a programmable window of `ce` cycles. Each window total, a running maximum and a sticky threshold flag go to the software register interface, so gain can be tuned by clip *rate* rather than a single sticky bit.

---
 rtl/adc_clip_rate_monitor.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/adc_clip_rate_monitor.sv
// adc_clip_rate_monitor
//   Counts ADC samples that sit on either signed full-scale code, summed over
//   a programmable window of ce cycles. Each completed window total is
//   published together with a running maximum and a sticky threshold flag.
//
// Ports
//   clk, rst     : system clock, synchronous active-high reset
//   ce           : clock enable for pipeline, window counter and accumulator
//   din          : PARALLEL_STREAMS signed samples, stream k at [k*DIN_WIDTH +: DIN_WIDTH]
//   win_len      : window length in ce cycles (0 behaves as 1)
//   thresh       : per-window clip-count threshold
//   clear        : clears max_count and over_thresh only
//   count_out    : clipped-sample total of the last completed window
//   count_valid  : one-cycle strobe when count_out updates
//   max_count    : largest count_out since reset/clear
//   over_thresh  : sticky, set when a window total >= thresh
module adc_clip_rate_monitor #(
  parameter int DIN_WIDTH        = 8,
  parameter int PARALLEL_STREAMS = 8,
  parameter int WINDOW_BITS      = 16,
  parameter int COUNT_WIDTH      = 24
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ce,
  input  logic [PARALLEL_STREAMS*DIN_WIDTH-1:0]  din,
  input  logic [WINDOW_BITS-1:0]                 win_len,
  input  logic [COUNT_WIDTH-1:0]                 thresh,
  input  logic                                   clear,
  output logic [COUNT_WIDTH-1:0]                 count_out,
  output logic                                   count_valid,
  output logic [COUNT_WIDTH-1:0]                 max_count,
  output logic                                   over_thresh
);
  localparam int PCW = $clog2(PARALLEL_STREAMS + 1);
  localparam int CWP = COUNT_WIDTH + 1;
  localparam logic [DIN_WIDTH-1:0]   POS_FS = {1'b0, {(DIN_WIDTH-1){1'b1}}};
  localparam logic [DIN_WIDTH-1:0]   NEG_FS = {1'b1, {(DIN_WIDTH-1){1'b0}}};
  localparam logic [WINDOW_BITS-1:0] ONE_W  = WINDOW_BITS'(1);

  // ---------------- per-stream clip detect ----------------
  logic [PARALLEL_STREAMS-1:0] clip_flags;

  for (genvar k = 0; k < PARALLEL_STREAMS; k++) begin : g_lane
    logic [DIN_WIDTH-1:0] smp;
    assign smp           = din[k*DIN_WIDTH +: DIN_WIDTH];
    assign clip_flags[k] = (smp == POS_FS) || (smp == NEG_FS);
  end

  // ---------------- window counter ----------------
  logic [WINDOW_BITS-1:0] win_cnt_q, win_cnt_d;
  logic [WINDOW_BITS-1:0] len_q, len_d;
  logic [WINDOW_BITS-1:0] cur_len;
  logic                   win_last;

  always_comb begin
    // Length is sampled at the first cycle of a window and frozen after, so
    // a win_len change mid-window only affects the following window.
    cur_len = len_q;
    if (win_cnt_q == '0) cur_len = (win_len == '0) ? ONE_W : win_len;
    win_last  = (win_cnt_q == cur_len - ONE_W);
    win_cnt_d = win_last ? '0 : win_cnt_q + ONE_W;
    len_d     = cur_len;
  end

  // ---------------- stages 1/2: flags, popcount ----------------
  logic [PARALLEL_STREAMS-1:0] flags_q;
  logic                        last1_q, last2_q;
  logic [PCW-1:0]              pc_q, pc_d;

  always_comb begin
    pc_d = '0;
    for (int k = 0; k < PARALLEL_STREAMS; k++) pc_d = pc_d + PCW'(flags_q[k]);
  end

  // ---------------- stage 3: accumulate / publish ----------------
  logic [COUNT_WIDTH-1:0] acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] max_q, max_d;
  logic                   vld_q, vld_d;
  logic                   over_q, over_d;
  logic [COUNT_WIDTH:0]   sum_wide;
  logic [COUNT_WIDTH-1:0] sum_sat;

  always_comb begin
    sum_wide = {1'b0, acc_q} + CWP'(pc_q);
    sum_sat  = sum_wide[COUNT_WIDTH] ? '1 : sum_wide[COUNT_WIDTH-1:0];

    acc_d  = acc_q;
    cnt_d  = cnt_q;
    vld_d  = 1'b0;
    max_d  = max_q;
    over_d = over_q;

    if (clear) begin
      max_d  = '0;
      over_d = 1'b0;
    end

    if (ce) begin
      if (last2_q) begin
        // Closing sample is folded into the published total; the
        // accumulator restarts empty for the next window's first sample,
        // which is one stage behind and lands next ce cycle.
        acc_d = '0;
        cnt_d = sum_sat;
        vld_d = 1'b1;
        // Applied after clear, so a coincident completion wins.
        if (sum_sat > max_d) max_d = sum_sat;
        if (sum_sat >= thresh) over_d = 1'b1;
      end else begin
        acc_d = sum_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q <= '0;
      len_q     <= '0;
      flags_q   <= '0;
      last1_q   <= 1'b0;
      pc_q      <= '0;
      last2_q   <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      vld_q     <= 1'b0;
      max_q     <= '0;
      over_q    <= 1'b0;
    end else begin
      if (ce) begin
        win_cnt_q <= win_cnt_d;
        len_q     <= len_d;
        flags_q   <= clip_flags;
        last1_q   <= win_last;
        pc_q      <= pc_d;
        last2_q   <= last1_q;
      end
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      max_q  <= max_d;
      over_q <= over_d;
    end
  end

  assign count_out   = cnt_q;
  assign count_valid = vld_q;
  assign max_count   = max_q;
  assign over_thresh = over_q;

endmodule
